// File: rtl/aes_iter_core_if.sv
// Accept/complete bundle for aes_iter_core. The abort wire exists only when AES_ABORT_EN is defined.
interface aes_iter_core_if #(
  parameter int KEY_BITS = 128
);
  logic                i_en;
  logic [KEY_BITS-1:0] key;
  logic [127:0]        data_in;
  logic                ready;
  logic [127:0]        data_out;
  logic                o_en;
`ifdef AES_ABORT_EN
  logic                abort;

  modport master (output i_en, key, data_in, abort, input ready, data_out, o_en);
  modport slave  (input i_en, key, data_in, abort, output ready, data_out, o_en);
`else
  modport master (output i_en, key, data_in, input ready, data_out, o_en);
  modport slave  (input i_en, key, data_in, output ready, data_out, o_en);
`endif
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly.
// Optional AES_ABORT_EN adds an abort input that drops the block in flight.
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic            clk,
  input  logic            rst,
  aes_iter_core_if.slave  bus
);
  localparam int         NR    = (KEY_BITS == 256) ? 14 : 10;
  localparam bit         IS256 = (KEY_BITS == 256);
  localparam logic [3:0] NR_L  = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_rnd;
  logic [127:0] r_st, r_ka, r_kb, r_dout;
  logic [7:0]   r_rcon;
  logic         r_oen;
  logic         w_accept, w_last, w_abort, w_rot, w_kupd;
  logic [127:0] w_sr, w_mc, w_rk, w_res, w_kbase;
  logic [31:0]  w_t, w_k0, w_k1, w_k2, w_k3;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, y;
    r = 8'h01;
    y = x;
    for (int i = 1; i < 8; i++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef AES_ABORT_EN
  assign w_abort = (r_state == S_RUN) && bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.i_en;
  assign w_last   = (r_state == S_RUN) && (r_rnd == NR_L);
  // AES-256 rotates and applies Rcon only on even rounds; AES-128 on every round
  assign w_rot    = !IS256 || !r_rnd[0];
  // AES-256 round 1 uses the low key half directly, so the key pair does not shift
  assign w_kupd   = !IS256 || (r_rnd != 4'd1);

  always_comb begin
    w_sr = '0;
    w_mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[127-8*(r+4*c) -: 8] = sbox(r_st[127-8*(r+4*((c+r)%4)) -: 8]);
    for (int c = 0; c < 4; c++)
      w_mc[127-32*c -: 32] = mixcol(w_sr[127-32*c -: 32]);

    w_kbase = IS256 ? r_ka : r_kb;
    w_t  = subword(w_rot ? {r_kb[23:0], r_kb[31:24]} : r_kb[31:0]) ^
           {(w_rot ? r_rcon : 8'h00), 24'h000000};
    w_k0 = w_kbase[127:96] ^ w_t;
    w_k1 = w_kbase[95:64]  ^ w_k0;
    w_k2 = w_kbase[63:32]  ^ w_k1;
    w_k3 = w_kbase[31:0]   ^ w_k2;
    w_rk = (IS256 && r_rnd == 4'd1) ? r_kb : {w_k0, w_k1, w_k2, w_k3};

    w_res = ((r_rnd == NR_L) ? w_sr : w_mc) ^ w_rk;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_en) w_state_nxt = S_RUN;
      S_RUN:   if (w_abort || w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd  <= '0;
      r_st   <= '0;
      r_ka   <= '0;
      r_kb   <= '0;
      r_rcon <= '0;
      r_dout <= '0;
      r_oen  <= 1'b0;
    end else begin
      r_oen <= 1'b0;
      if (w_accept) begin
        r_st   <= bus.data_in ^ bus.key[KEY_BITS-1 -: 128];
        r_ka   <= bus.key[KEY_BITS-1 -: 128];
        r_kb   <= bus.key[127:0];
        r_rcon <= 8'h01;
        r_rnd  <= 4'd1;
      end else if (w_abort) begin
        r_rnd <= '0;
      end else if (r_state == S_RUN) begin
        r_st <= w_res;
        if (w_kupd) begin
          r_ka <= r_kb;
          r_kb <= w_rk;
        end
        if (w_rot) r_rcon <= xtime(r_rcon);
        if (w_last) begin
          r_dout <= w_res;
          r_oen  <= 1'b1;
          r_rnd  <= '0;
        end else begin
          r_rnd <= r_rnd + 4'd1;
        end
      end
    end
  end

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.data_out = r_dout;
  assign bus.o_en     = r_oen;
endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core: one AES-128 and one AES-256 instance with FIPS-197 vectors.
module tb_aes_iter_core;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst128, rst256;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q128[$];
  exp_t q256[$];

  aes_iter_core_if #(.KEY_BITS(128)) bus128();
  aes_iter_core_if #(.KEY_BITS(256)) bus256();

  aes_iter_core #(.KEY_BITS(128)) u_dut128 (.clk(clk), .rst(rst128), .bus(bus128));
  aes_iter_core #(.KEY_BITS(256)) u_dut256 (.clk(clk), .rst(rst256), .bus(bus256));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called right after a falling edge; the block is accepted at the next rising edge.
  task automatic send128(input logic [127:0] k, input logic [127:0] pt,
                         input logic [127:0] ct, input bit track);
    exp_t e;
    bus128.i_en    = 1'b1;
    bus128.key     = k;
    bus128.data_in = pt;
    if (track) begin
      e.ct  = ct;
      e.due = cyc + 1 + 10;
      q128.push_back(e);
    end
    @(negedge clk);
    bus128.i_en = 1'b0;
  endtask

  task automatic send256(input logic [255:0] k, input logic [127:0] pt,
                         input logic [127:0] ct);
    exp_t e;
    bus256.i_en    = 1'b1;
    bus256.key     = k;
    bus256.data_in = pt;
    e.ct  = ct;
    e.due = cyc + 1 + 14;
    q256.push_back(e);
    @(negedge clk);
    bus256.i_en = 1'b0;
  endtask

  initial begin : mon128
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus128.o_en === 1'b1) begin
        check("oen128_single", {127'd0, prev}, 128'd0);
        if (q128.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL oen128_unexpected: got o_en=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q128.pop_front();
          check("ct128", bus128.data_out, e.ct);
          check("lat128", 128'(cyc), 128'(e.due));
        end
      end
      prev = bus128.o_en;
    end
  end

  initial begin : mon256
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus256.o_en === 1'b1) begin
        check("oen256_single", {127'd0, prev}, 128'd0);
        if (q256.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL oen256_unexpected: got o_en=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q256.pop_front();
          check("ct256", bus256.data_out, e.ct);
          check("lat256", 128'(cyc), 128'(e.due));
        end
      end
      prev = bus256.o_en;
    end
  end

  initial begin : stim
    bus128.i_en = 1'b0;  bus128.key = '0;  bus128.data_in = '0;
    bus256.i_en = 1'b0;  bus256.key = '0;  bus256.data_in = '0;
`ifdef AES_ABORT_EN
    bus128.abort = 1'b0;
    bus256.abort = 1'b0;
`endif
    rst128 = 1'b1;
    rst256 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready128", bus128.ready, 1);
    check("rst_oen128", bus128.o_en, 0);
    check("rst_dout128", bus128.data_out, 0);
    check("rst_ready256", bus256.ready, 1);
    check("rst_dout256", bus256.data_out, 0);
    rst128 = 1'b0;
    rst256 = 1'b0;

    // Two AES-128 blocks, the second issued in the completion cycle of the first
    @(negedge clk);
    send128(K1, P1, C1, 1'b1);
    check("busy_ready128", bus128.ready, 0);
    repeat (10) @(negedge clk);
    check("ready_in_oen128", bus128.ready, 1);
    send128(K2, P2, C2, 1'b1);
    repeat (10) @(negedge clk);
    repeat (2) @(negedge clk);

    // Start strobe three cycles into a run must be ignored
    send128(K1, P1, C1, 1'b1);
    repeat (2) @(negedge clk);
    check("ign_ready128", bus128.ready, 0);
    bus128.i_en    = 1'b1;
    bus128.key     = K2;
    bus128.data_in = P2;
    @(negedge clk);
    bus128.i_en = 1'b0;
    repeat (12) @(negedge clk);

    // Reset while round 5 is pending
    send128(K2, P2, C2, 1'b0);
    repeat (4) @(negedge clk);
    rst128 = 1'b1;
    @(negedge clk);
    rst128 = 1'b0;
    check("midrst_ready128", bus128.ready, 1);
    check("midrst_dout128", bus128.data_out, 0);
    check("midrst_oen128", bus128.o_en, 0);
    repeat (12) @(negedge clk);
    send128(K1, P1, C1, 1'b1);
    repeat (12) @(negedge clk);

`ifdef AES_ABORT_EN
    send128(K2, P2, C2, 1'b0);
    repeat (3) @(negedge clk);
    bus128.abort = 1'b1;
    @(negedge clk);
    bus128.abort = 1'b0;
    check("abort_ready128", bus128.ready, 1);
    check("abort_dout128", bus128.data_out, C1);
    check("abort_oen128", bus128.o_en, 0);
    @(negedge clk);
    send128(K2, P2, C2, 1'b1);
    repeat (12) @(negedge clk);
`endif

    // AES-256 block followed back-to-back by a second one
    send256(K3, P2, C3);
    check("busy_ready256", bus256.ready, 0);
    repeat (14) @(negedge clk);
    check("ready_in_oen256", bus256.ready, 1);
    send256(K3, P2, C3);
    repeat (16) @(negedge clk);

    check("pending128", 128'(q128.size()), 128'd0);
    check("pending256", 128'(q256.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
